// File: rtl/tile_sequencer.sv
// tile_sequencer: layer-level scheduler for the systolic-array tile controller.
// Walks weight tiles (outer loop) and input-feature tiles (inner loop). For
// each tile it presents base addresses and an accumulate-clear flag, then
// runs one start/ready handshake with the controller. A one-cycle
// layer_done pulse marks the end of the layer.
module tile_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 8,
    parameter int W_STRIDE  = 64,
    parameter int IF_STRIDE = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_n_w,
    input  logic [CNT_W-1:0]  cfg_n_if,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_if_base,
    input  logic              abort,
    output logic              ctrl_start,
    input  logic              ctrl_ready,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] if_addr,
    output logic [CNT_W-1:0]  w_idx,
    output logic [CNT_W-1:0]  if_idx,
    output logic              acc_clr,
    output logic              busy,
    output logic              layer_done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_ADVANCE   = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Strides reduced to address width: address arithmetic wraps silently.
    localparam logic [ADDR_W-1:0] W_STEP  = ADDR_W'(W_STRIDE);
    localparam logic [ADDR_W-1:0] IF_STEP = ADDR_W'(IF_STRIDE);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            state_r;
    state_t            state_next_s;

    logic [CNT_W-1:0]  n_w_r;
    logic [CNT_W-1:0]  n_if_r;
    logic [ADDR_W-1:0] if_base_r;
    logic [CNT_W-1:0]  w_idx_r;
    logic [CNT_W-1:0]  if_idx_r;
    logic [ADDR_W-1:0] w_addr_r;
    logic [ADDR_W-1:0] if_addr_r;
    logic              acc_clr_r;

    logic              ctrl_start_r;
    logic              cfg_ready_r;
    logic              busy_r;
    logic              layer_done_r;

    logic              load_s;
    logic              step_if_s;
    logic              step_w_s;
    logic              last_if_s;
    logic              last_w_s;

    // Unsigned counts: the last tile is index n-1, so 255 means 255 tiles.
    assign last_if_s = (if_idx_r == (n_if_r - CNT_ONE));
    assign last_w_s  = (w_idx_r  == (n_w_r  - CNT_ONE));

    // Next-state decode plus the datapath load/step strobes for this cycle.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_if_s    = 1'b0;
        step_w_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // abort has no effect here; a descriptor is always taken.
                if (cfg_valid) begin
                    load_s = 1'b1;
                    if ((cfg_n_w == CNT_ZERO) || (cfg_n_if == CNT_ZERO)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ISSUE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (ctrl_ready) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_START: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (!ctrl_ready) begin
                    state_next_s = ST_WAIT_DONE;
                end else begin
                    state_next_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (ctrl_ready) begin
                    state_next_s = ST_ADVANCE;
                end else begin
                    state_next_s = ST_WAIT_DONE;
                end
            end
            ST_ADVANCE: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (!last_if_s) begin
                    step_if_s    = 1'b1;
                    state_next_s = ST_ISSUE;
                end else if (!last_w_s) begin
                    step_w_s     = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and handshake/status outputs, registered from next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            ctrl_start_r <= 1'b0;
            cfg_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            layer_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            ctrl_start_r <= (state_next_s == ST_START);
            cfg_ready_r  <= (state_next_s == ST_IDLE);
            busy_r       <= (state_next_s != ST_IDLE);
            layer_done_r <= (state_next_s == ST_DONE);
        end
    end

    // Descriptor latch and tile walk; indices and addresses move only on
    // accept or on the ADVANCE edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_w_r     <= CNT_ZERO;
            n_if_r    <= CNT_ZERO;
            if_base_r <= {ADDR_W{1'b0}};
            w_idx_r   <= CNT_ZERO;
            if_idx_r  <= CNT_ZERO;
            w_addr_r  <= {ADDR_W{1'b0}};
            if_addr_r <= {ADDR_W{1'b0}};
            acc_clr_r <= 1'b0;
        end else if (load_s) begin
            n_w_r     <= cfg_n_w;
            n_if_r    <= cfg_n_if;
            if_base_r <= cfg_if_base;
            w_idx_r   <= CNT_ZERO;
            if_idx_r  <= CNT_ZERO;
            w_addr_r  <= cfg_w_base;
            if_addr_r <= cfg_if_base;
            acc_clr_r <= 1'b1;
        end else if (step_if_s) begin
            if_idx_r  <= if_idx_r + CNT_ONE;
            if_addr_r <= if_addr_r + IF_STEP;
            acc_clr_r <= 1'b0;
        end else if (step_w_s) begin
            w_idx_r   <= w_idx_r + CNT_ONE;
            w_addr_r  <= w_addr_r + W_STEP;
            if_idx_r  <= CNT_ZERO;
            if_addr_r <= if_base_r;
            acc_clr_r <= 1'b1;
        end
    end

    assign cfg_ready  = cfg_ready_r;
    assign ctrl_start = ctrl_start_r;
    assign busy       = busy_r;
    assign layer_done = layer_done_r;
    assign w_addr     = w_addr_r;
    assign if_addr    = if_addr_r;
    assign w_idx      = w_idx_r;
    assign if_idx     = if_idx_r;
    assign acc_clr    = acc_clr_r;

endmodule

// File: tb/tb_tile_sequencer.sv
// Testbench for tile_sequencer: directed and randomized layers against a
// nested-loop reference model, with a behavioural tile controller.
module tb_tile_sequencer;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_n_w;
    logic [CNT_W-1:0]  cfg_n_if;
    logic [ADDR_W-1:0] cfg_w_base;
    logic [ADDR_W-1:0] cfg_if_base;
    logic              abort;
    logic              ctrl_start;
    logic              ctrl_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] if_addr;
    logic [CNT_W-1:0]  w_idx;
    logic [CNT_W-1:0]  if_idx;
    logic              acc_clr;
    logic              busy;
    logic              layer_done;

    always #5 clk = ~clk;

    tile_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .W_STRIDE(64), .IF_STRIDE(64)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n_w(cfg_n_w), .cfg_n_if(cfg_n_if), .cfg_w_base(cfg_w_base),
        .cfg_if_base(cfg_if_base), .abort(abort), .ctrl_start(ctrl_start),
        .ctrl_ready(ctrl_ready), .w_addr(w_addr), .if_addr(if_addr),
        .w_idx(w_idx), .if_idx(if_idx), .acc_clr(acc_clr), .busy(busy),
        .layer_done(layer_done)
    );

    typedef struct {
        int w; int i; int wa; int ia; int clr; int c; int rr;
    } tile_t;

    tile_t obs_q[$];
    tile_t exp_q[$];
    int    done_q[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int consec = 0;
    int ready_rise_cyc = 0;
    int ack_lo = 1;
    int ack_hi = 1;
    int busy_lo = 2;
    int busy_hi = 4;
    bit prev_start = 1'b0;

    // cycle counter, advanced on the active edge
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // monitor: record every start (with tile info) and every layer_done
    initial begin : monitor
        tile_t t;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (ctrl_start === 1'b1) begin
                    t.w   = int'(w_idx);
                    t.i   = int'(if_idx);
                    t.wa  = int'(w_addr);
                    t.ia  = int'(if_addr);
                    t.clr = int'(acc_clr);
                    t.c   = cyc;
                    t.rr  = ready_rise_cyc;
                    obs_q.push_back(t);
                    if (prev_start) consec = consec + 1;
                end
                prev_start = (ctrl_start === 1'b1);
                if (layer_done === 1'b1) done_q.push_back(cyc);
            end else begin
                prev_start = 1'b0;
            end
        end
    end

    // behavioural tile controller: drops ready after a delay, raises it later
    initial begin : ctrl_model
        int a;
        int b;
        ctrl_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && ctrl_start === 1'b1) begin
                a = int'($urandom_range(ack_hi, ack_lo));
                b = int'($urandom_range(busy_hi, busy_lo));
                repeat (a) @(negedge clk);
                ctrl_ready = 1'b0;
                repeat (b) @(negedge clk);
                ctrl_ready = 1'b1;
                ready_rise_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // reference: the tile order a layer must produce, from the loop rules
    task automatic build_expected(input int nw, input int nif, input int wb, input int ib);
        tile_t t;
        exp_q.delete();
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < nif; i++) begin
                t.w   = w;
                t.i   = i;
                t.wa  = (wb + w * 64) % 65536;
                t.ia  = (ib + i * 64) % 65536;
                t.clr = (i == 0) ? 1 : 0;
                t.c   = 0;
                t.rr  = 0;
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic compare_tiles(input string name);
        int n;
        chk($sformatf("%s start count", name), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s[%0d] w_idx", name, k),   obs_q[k].w,   exp_q[k].w);
            chk($sformatf("%s[%0d] if_idx", name, k),  obs_q[k].i,   exp_q[k].i);
            chk($sformatf("%s[%0d] w_addr", name, k),  obs_q[k].wa,  exp_q[k].wa);
            chk($sformatf("%s[%0d] if_addr", name, k), obs_q[k].ia,  exp_q[k].ia);
            chk($sformatf("%s[%0d] acc_clr", name, k), obs_q[k].clr, exp_q[k].clr);
        end
    endtask

    // called at a negedge: present a descriptor for one cycle
    task automatic start_layer(input int nw, input int nif, input int wb, input int ib,
                               input logic ab, output int dcyc);
        int guard = 0;
        while (cfg_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("cfg_ready before accept", 32'(cfg_ready), 32'd1);
        obs_q.delete();
        done_q.delete();
        build_expected(nw, nif, wb, ib);
        cfg_n_w     = CNT_W'(nw);
        cfg_n_if    = CNT_W'(nif);
        cfg_w_base  = ADDR_W'(wb);
        cfg_if_base = ADDR_W'(ib);
        cfg_valid   = 1'b1;
        abort       = ab;
        dcyc        = cyc;
        @(negedge clk);
        cfg_valid   = 1'b0;
        abort       = 1'b0;
        cfg_n_w     = CNT_W'($urandom);
        cfg_n_if    = CNT_W'($urandom);
        cfg_w_base  = ADDR_W'($urandom);
        cfg_if_base = ADDR_W'($urandom);
        chk("busy after accept", 32'(busy), 32'd1);
        chk("cfg_ready after accept", 32'(cfg_ready), 32'd0);
    endtask

    task automatic finish_layer(input string name, input int budget, input bit check_rise);
        int guard = 0;
        while (done_q.size() == 0 && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("%s layer_done seen", name), 32'(done_q.size() > 0), 32'd1);
        chk($sformatf("%s cfg_ready during done", name), 32'(cfg_ready), 32'd0);
        if (check_rise && done_q.size() > 0)
            chk($sformatf("%s done after last tile", name), done_q[0], ready_rise_cyc + 2);
        @(negedge clk);
        chk($sformatf("%s cfg_ready after done", name), 32'(cfg_ready), 32'd1);
        chk($sformatf("%s busy after done", name), 32'(busy), 32'd0);
        @(negedge clk);
        chk($sformatf("%s layer_done count", name), done_q.size(), 32'd1);
        chk($sformatf("%s no back-to-back start", name), consec, 32'd0);
        compare_tiles(name);
    endtask

    initial begin : stim
        int d;
        int guard;
        int nw;
        int nif;
        rst         = 1'b0;
        cfg_valid   = 1'b0;
        abort       = 1'b0;
        cfg_n_w     = '0;
        cfg_n_if    = '0;
        cfg_w_base  = '0;
        cfg_if_base = '0;

        // reset with random inputs for three cycles
        repeat (3) begin
            cfg_valid   = 1'($urandom);
            abort       = 1'($urandom);
            cfg_n_w     = CNT_W'($urandom);
            cfg_n_if    = CNT_W'($urandom);
            cfg_w_base  = ADDR_W'($urandom);
            cfg_if_base = ADDR_W'($urandom);
            @(negedge clk);
        end
        chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
        chk("reset ctrl_start", 32'(ctrl_start), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset layer_done", 32'(layer_done), 32'd0);
        chk("reset w_addr", 32'(w_addr), 32'd0);
        chk("reset if_addr", 32'(if_addr), 32'd0);
        chk("reset w_idx", 32'(w_idx), 32'd0);
        chk("reset if_idx", 32'(if_idx), 32'd0);
        chk("reset acc_clr", 32'(acc_clr), 32'd0);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);

        // abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle abort cfg_ready", 32'(cfg_ready), 32'd1);
        chk("idle abort busy", 32'(busy), 32'd0);

        // single tile, controller acks after 1 cycle, busy for 10
        ack_lo = 1; ack_hi = 1; busy_lo = 10; busy_hi = 10;
        start_layer(1, 1, 32'h0100, 32'h0200, 1'b0, d);
        finish_layer("single", 200, 1'b1);
        if (obs_q.size() > 0 && done_q.size() > 0) begin
            chk("single start latency", obs_q[0].c - d, 32'd2);
            chk("single done latency", done_q[0] - obs_q[0].c, 32'd13);
        end

        // full 2x3 loop with varied controller timing
        ack_lo = 0; ack_hi = 2; busy_lo = 2; busy_hi = 5;
        start_layer(2, 3, 32'h0100, 32'h0200, 1'b0, d);
        finish_layer("full", 400, 1'b1);
        if (obs_q.size() > 0) chk("full start latency", obs_q[0].c - d, 32'd2);

        // zero counts: no start, done one cycle after accept
        start_layer(0, 5, 32'h1000, 32'h2000, 1'b0, d);
        finish_layer("zero_w", 20, 1'b0);
        if (done_q.size() > 0) chk("zero_w done latency", done_q[0] - d, 32'd1);
        start_layer(3, 0, 32'h1000, 32'h2000, 1'b0, d);
        finish_layer("zero_if", 20, 1'b0);
        if (done_q.size() > 0) chk("zero_if done latency", done_q[0] - d, 32'd1);

        // address wrap; abort together with cfg_valid in IDLE still accepts
        start_layer(2, 1, 32'hFFC0, 32'h1234, 1'b1, d);
        finish_layer("wrap", 200, 1'b1);

        // randomized layers
        for (int r = 0; r < 5; r++) begin
            nw  = int'($urandom_range(3, 1));
            nif = int'($urandom_range(4, 1));
            start_layer(nw, nif, int'($urandom_range(65535, 0)),
                        int'($urandom_range(65535, 0)), 1'b0, d);
            finish_layer($sformatf("rand%0d", r), 400, 1'b1);
        end

        // maximum count on the inner loop
        ack_lo = 0; ack_hi = 1; busy_lo = 2; busy_hi = 3;
        start_layer(1, 255, 32'h0040, 32'h8000, 1'b0, d);
        finish_layer("max255", 255 * 12 + 100, 1'b1);

        // abort during WAIT_DONE of tile 2
        ack_lo = 1; ack_hi = 1; busy_lo = 10; busy_hi = 10;
        start_layer(2, 2, 32'h0400, 32'h0800, 1'b0, d);
        guard = 0;
        while (obs_q.size() < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("abort second start seen", 32'(obs_q.size() >= 2), 32'd1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort cfg_ready", 32'(cfg_ready), 32'd1);
        chk("abort ctrl_start", 32'(ctrl_start), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort no layer_done", done_q.size(), 32'd0);
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        compare_tiles("abort");

        // next layer must wait for the in-flight tile to finish
        start_layer(1, 1, 32'h0500, 32'h0600, 1'b0, d);
        finish_layer("post_abort", 200, 1'b1);
        if (obs_q.size() > 0) begin
            chk("post_abort start after ready", obs_q[0].c, obs_q[0].rr + 1);
            chk("post_abort delayed", 32'(obs_q[0].c - d > 2), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tile_sequencer.md
# tile_sequencer

Layer-level scheduler that sits above the systolic-array tile controller and drives its `start`/`ready` handshake once per (weight tile, input-feature tile) pair. It accepts one layer descriptor (tile counts and base addresses) and walks weight tiles in the outer loop and input-feature tiles in the inner loop. For each tile it presents the buffer base addresses and an accumulate-clear flag, then waits for the controller to finish. It reports layer completion with a single-cycle pulse.

## Interface
- `ADDR_W`, 16, width of buffer base addresses.
- `CNT_W`, 8, width of tile counts and tile indices.
- `W_STRIDE`, 64, address increment between consecutive weight tiles.
- `IF_STRIDE`, 64, address increment between consecutive input-feature tiles.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cfg_valid` in 1: layer descriptor valid.
- `cfg_ready` out 1: sequencer idle and able to accept a descriptor.
- `cfg_n_w` in CNT_W: number of weight tiles.
- `cfg_n_if` in CNT_W: number of input-feature tiles.
- `cfg_w_base` in ADDR_W: first weight tile address.
- `cfg_if_base` in ADDR_W: first input-feature tile address.
- `abort` in 1: synchronous cancel of the current layer.
- `ctrl_start` out 1: one-cycle start pulse to the tile controller.
- `ctrl_ready` in 1: tile controller idle/finished indication.
- `w_addr` out ADDR_W: current weight tile address.
- `if_addr` out ADDR_W: current input-feature tile address.
- `w_idx` out CNT_W: current weight tile index.
- `if_idx` out CNT_W: current input-feature tile index.
- `acc_clr` out 1: high while the current tile is the first input-feature tile of its weight tile (`if_idx==0`).
- `busy` out 1: high in every state except IDLE.
- `layer_done` out 1: one-cycle pulse when all tiles have completed.

## Operation
- States are IDLE, ISSUE, START, WAIT_ACK, WAIT_DONE, ADVANCE and DONE.
- **IDLE:**
  - `cfg_ready=1`.
  - On `cfg_valid`, latch the counts and bases, clear `w_idx`/`if_idx`, and load `w_addr=cfg_w_base` and `if_addr=cfg_if_base`.
  - If either count is 0, go to DONE; otherwise go to ISSUE.
- **ISSUE:** wait for `ctrl_ready=1`, then go to START.
- **START:** `ctrl_start=1` for exactly this cycle, then go to WAIT_ACK.
- **WAIT_ACK:** wait for `ctrl_ready=0` (controller has accepted), then go to WAIT_DONE.
- **WAIT_DONE:** wait for `ctrl_ready=1` (tile complete), then go to ADVANCE.
- **ADVANCE:**
  - If `if_idx` is not the last input-feature tile: `if_idx+1` and `if_addr+=IF_STRIDE`.
  - Else, if `w_idx` is not the last weight tile: clear `if_idx`, reload `if_addr=if_base`, `w_idx+1` and `w_addr+=W_STRIDE`.
  - Else go to DONE. In all non-final cases go to ISSUE.
- **DONE:** `layer_done=1` for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent and not flagged.
- Counts are unsigned: 255 with CNT_W=8 gives 255 tiles. Index comparison is `idx == n-1`.
- `w_addr`, `if_addr`, `w_idx`, `if_idx` and `acc_clr` are registered. They are stable from ISSUE through WAIT_DONE and change only on the ADVANCE edge.
- `abort` in any non-IDLE state forces IDLE on the next edge. There is no `layer_done`, and `ctrl_start` is never issued in the cycle after an abort. An in-flight controller tile is left to finish; the next layer's ISSUE waits for `ctrl_ready`. `abort` in IDLE has no effect.
- If `cfg_valid` and `abort` are both high in IDLE, the descriptor is accepted.
- Descriptor inputs are ignored outside IDLE.

## Timing
- Reset values:
  - state IDLE, `cfg_ready=1`.
  - `ctrl_start=0`, `busy=0`, `layer_done=0`.
  - Addresses, indices and `acc_clr` are 0.
- Latency from descriptor accept to first `ctrl_start`: 2 cycles when `ctrl_ready` is already high (accept edge → ISSUE → START).
- Per-tile overhead beyond controller time: ISSUE, START and ADVANCE, i.e. 3 cycles plus 1 cycle of WAIT_ACK if the controller drops `ready` one cycle after `start`.
- `layer_done` asserts the cycle after the final ADVANCE. `cfg_ready` returns the cycle after that.
- With a zero count, `layer_done` asserts 1 cycle after accept, with no `ctrl_start`.
- `ctrl_start` is never high on two consecutive cycles.

## Test plan
- **Reset:** hold `rst=0` for 3 cycles with random inputs → all outputs at reset values, `cfg_ready=1`.
- **Single tile:**
  - Stimulus: `n_w=1`, `n_if=1`, bases 0x0100/0x0200; controller drops `ready` 1 cycle after `start` and raises it 10 cycles later.
  - Required: one `ctrl_start` at accept+2 with `w_addr=0x0100`, `if_addr=0x0200`, `acc_clr=1`; `layer_done` exactly once.
- **Full loop:**
  - Stimulus: `n_w=2`, `n_if=3`, strides 64.
  - Required: 6 starts in the order (w,if) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); `if_addr` sequence 0x200,0x240,0x280 repeating; `acc_clr` only on if=0.
- **Zero count:** `n_w=0`, `n_if=5` → no `ctrl_start`; `layer_done` at accept+1.
- **Wrap:** `w_base=0xFFC0`, `n_w=2`, `n_if=1` → second tile `w_addr=0x0000`.
- **Abort:** assert `abort` during WAIT_DONE of tile 2 → IDLE next edge, no `layer_done`. The next descriptor waits for `ctrl_ready` before issuing `ctrl_start`.
